// File: rtl/sync_event_arbiter_if.sv
// Event grant channel between sync_event_arbiter and its single downstream consumer.
// Valid/ready: the master raises evt_valid_o and holds evt_valid_o/evt_idx_o stable until a
// clock edge where evt_ready_i is also high; that edge is the transfer. Ready is ignored while valid is low.
interface sync_event_arbiter_if #(
    parameter int IDX_WIDTH = 2
) ();
    logic                 evt_valid_o;
    logic [IDX_WIDTH-1:0] evt_idx_o;
    logic                 evt_ready_i;

    modport master (output evt_valid_o, output evt_idx_o, input evt_ready_i);
    modport slave  (input evt_valid_o, input evt_idx_o, output evt_ready_i);
endinterface

// File: rtl/sync_event_arbiter.sv
// Turns synchronized source levels into pending events and grants them one at a time,
// round-robin, over a valid/ready channel; repeated events on a still-pending source flag overflow.
module sync_event_arbiter #(
    parameter int DLY       = 1,
    parameter int REQ_NUM   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [REQ_NUM-1:0]   sync_lvl_i,
    sync_event_arbiter_if.master evt_if,
    output logic [REQ_NUM-1:0]   ovf_o,
    input  logic [REQ_NUM-1:0]   ovf_clr_i,
    output logic                 busy_o,
    output logic                 dbg_state_o
);

    if (REQ_NUM < 2) begin : g_bad_req_num
        $error("REQ_NUM must be at least 2");
    end
    if ((2 ** IDX_WIDTH) < REQ_NUM) begin : g_bad_idx_width
        $error("IDX_WIDTH too narrow for REQ_NUM");
    end
    // DLY is accepted for compatibility with the synchronizer bank; flops are modeled without delay.
    if (DLY < 0) begin : g_bad_dly
        $error("DLY must be non-negative");
    end

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t               state_q;
    logic [REQ_NUM-1:0]   prev_q;
    logic [REQ_NUM-1:0]   pend_q;
    logic [REQ_NUM-1:0]   ovf_q;
    logic [IDX_WIDTH-1:0] ptr_q;
    logic                 evt_valid_q;
    logic [IDX_WIDTH-1:0] evt_idx_q;

    logic [REQ_NUM-1:0]   evt;
    logic [REQ_NUM-1:0]   clr_vec;
    logic [REQ_NUM-1:0]   pend_d;
    logic [REQ_NUM-1:0]   ovf_d;
    logic                 accept;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;

    always_comb begin
        case (EDGE_MODE)
            1:       evt = ~sync_lvl_i & prev_q;
            2:       evt = sync_lvl_i ^ prev_q;
            default: evt = sync_lvl_i & ~prev_q;
        endcase
    end

    assign accept = evt_valid_q & evt_if.evt_ready_i;

    // A new event in the same cycle as the accept is kept, so set dominates clear on pend.
    always_comb begin
        clr_vec = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            clr_vec[k] = accept && (evt_idx_q == IDX_WIDTH'(k));
        end
        pend_d = (pend_q & ~clr_vec) | evt;
        ovf_d  = (ovf_q & ~ovf_clr_i) | (evt & pend_q & ~clr_vec);
    end

    // First pending source at or above ptr, wrapping past REQ_NUM-1 back to 0.
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            j = int'(ptr_q) + i;
            if (j >= REQ_NUM) j = j - REQ_NUM;
            if (!pick_found && pend_q[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_WIDTH'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
        end else begin
            prev_q <= sync_lvl_i;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        evt_idx_q   <= pick_idx;
                        evt_valid_q <= 1'b1;
                        state_q     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (evt_if.evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        if (evt_idx_q == IDX_WIDTH'(REQ_NUM - 1)) ptr_q <= '0;
                        else ptr_q <= evt_idx_q + IDX_WIDTH'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign evt_if.evt_valid_o = evt_valid_q;
    assign evt_if.evt_idx_o   = evt_idx_q;
    assign ovf_o              = ovf_q;
    assign busy_o             = (|pend_q) | evt_valid_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed bench for sync_event_arbiter: one instance per edge mode, shared clock and reset.
module tb_sync_event_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] lvl0, lvl1, lvl2;
  logic [3:0] clr0, clr1, clr2;
  logic [3:0] ovf0, ovf1, ovf2;
  logic       busy0, busy1, busy2;
  logic       st0, st1, st2;

  sync_event_arbiter_if #(.IDX_WIDTH(2)) if0 ();
  sync_event_arbiter_if #(.IDX_WIDTH(2)) if1 ();
  sync_event_arbiter_if #(.IDX_WIDTH(2)) if2 ();

  sync_event_arbiter #(.DLY(1), .REQ_NUM(4), .IDX_WIDTH(2), .EDGE_MODE(0)) u_rise (
    .clk_i(clk), .rst_n_i(rst_n), .sync_lvl_i(lvl0), .evt_if(if0),
    .ovf_o(ovf0), .ovf_clr_i(clr0), .busy_o(busy0), .dbg_state_o(st0));
  sync_event_arbiter #(.DLY(1), .REQ_NUM(4), .IDX_WIDTH(2), .EDGE_MODE(1)) u_fall (
    .clk_i(clk), .rst_n_i(rst_n), .sync_lvl_i(lvl1), .evt_if(if1),
    .ovf_o(ovf1), .ovf_clr_i(clr1), .busy_o(busy1), .dbg_state_o(st1));
  sync_event_arbiter #(.DLY(1), .REQ_NUM(4), .IDX_WIDTH(2), .EDGE_MODE(2)) u_both (
    .clk_i(clk), .rst_n_i(rst_n), .sync_lvl_i(lvl2), .evt_if(if2),
    .ovf_o(ovf2), .ovf_clr_i(clr2), .busy_o(busy2), .dbg_state_o(st2));

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] e;
    rst_n = 1'b0;
    lvl0 = '0; lvl1 = '0; lvl2 = '0;
    clr0 = '0; clr1 = '0; clr2 = '0;
    if0.evt_ready_i = 1'b1;
    if1.evt_ready_i = 1'b0;
    if2.evt_ready_i = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_valid", if0.evt_valid_o, 0);
    check("rst_idx", if0.evt_idx_o, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_busy", busy0, 0);
    check("rst_state", st0, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy0, 0);

    // simultaneous events, granted 0..3 two cycles apart
    for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
    lvl0 = 4'b1111;
    tick();
    check("sim_pend_busy", busy0, 1);
    check("sim_no_valid_yet", if0.evt_valid_o, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check("sim_valid", if0.evt_valid_o, 1);
      check("sim_idx", if0.evt_idx_o, e);
      tick();
      check("sim_gap", if0.evt_valid_o, 0);
    end
    check("sim_ovf", ovf0, 0);
    check("sim_done_busy", busy0, 0);

    // back-pressure on source 1
    lvl0 = 4'b0000;
    tick();
    if0.evt_ready_i = 1'b0;
    lvl0 = 4'b0010;
    tick();
    tick();
    check("bp_valid", if0.evt_valid_o, 1);
    check("bp_idx", if0.evt_idx_o, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", if0.evt_valid_o, 1);
      check("bp_hold_idx", if0.evt_idx_o, 1);
    end
    if0.evt_ready_i = 1'b1;
    tick();
    check("bp_accept", if0.evt_valid_o, 0);
    check("bp_busy", busy0, 0);

    // single event on source 2 (ptr is 2 here, afterwards 3)
    lvl0 = 4'b0000;
    tick();
    lvl0 = 4'b0100;
    tick();
    check("single_pend", busy0, 1);
    check("single_no_valid", if0.evt_valid_o, 0);
    tick();
    check("single_valid", if0.evt_valid_o, 1);
    check("single_idx", if0.evt_idx_o, 2);
    tick();
    check("single_accept", if0.evt_valid_o, 0);
    check("single_busy", busy0, 0);

    // fairness: from ptr=3 the search wraps to 0 before reaching 2
    lvl0 = 4'b0000;
    tick();
    lvl0 = 4'b0101;
    tick();
    tick();
    check("fair_first_idx", if0.evt_idx_o, 0);
    check("fair_first_valid", if0.evt_valid_o, 1);
    tick();
    tick();
    check("fair_second_idx", if0.evt_idx_o, 2);
    check("fair_second_valid", if0.evt_valid_o, 1);
    tick();
    check("fair_busy", busy0, 0);

    // overflow on both-edge instance
    lvl2[3] = 1'b1;
    tick();
    lvl2[3] = 1'b0;
    tick();
    check("ovf_set", ovf2, 4'b1000);
    check("ovf_valid", if2.evt_valid_o, 1);
    check("ovf_idx", if2.evt_idx_o, 3);
    clr2 = 4'b1000;
    lvl2[3] = 1'b1;
    tick();
    clr2 = 4'b0000;
    check("ovf_set_wins", ovf2, 4'b1000);
    clr2 = 4'b1000;
    tick();
    clr2 = 4'b0000;
    check("ovf_cleared", ovf2, 4'b0000);
    if2.evt_ready_i = 1'b1;
    tick();
    check("ovf_accept", if2.evt_valid_o, 0);
    check("ovf_single_grant", busy2, 0);
    tick();
    check("ovf_no_regrant", if2.evt_valid_o, 0);

    // reset mid-operation on falling-edge instance with three pending
    lvl1 = 4'b0111;
    tick();
    lvl1 = 4'b0000;
    tick();
    lvl1 = 4'b0111;
    tick();
    check("mid_valid", if1.evt_valid_o, 1);
    check("mid_idx", if1.evt_idx_o, 0);
    check("mid_state", st1, 1);
    rst_n = 1'b0;
    #1;
    check("async_valid", if1.evt_valid_o, 0);
    check("async_idx", if1.evt_idx_o, 0);
    check("async_busy", busy1, 0);
    check("async_ovf", ovf1, 0);
    check("async_state", st1, 0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_valid", if1.evt_valid_o, 0);
      check("post_rst_busy", busy1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
